cache_wb_xmt: RTL and testbench

CACHE_WB_XMT -- requirements
Module: cache_wb_xmt

---
 rtl/cache_wb_xmt_pkg.sv | 22 ++
 rtl/csh_wb_fifo.sv | 62 ++++++
 rtl/cache_wb_xmt.sv | 147 ++++++++++++++
 tb/tb_cache_wb_xmt.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_wb_xmt_pkg.sv
// Shared types, defaults and the per-slice odd-parity check for the cache writeback transmitter.
package cache_wb_xmt_pkg;

  localparam int unsigned WordsDef = 4;
  localparam int unsigned LineWDef = 7;
  localparam int unsigned WayWDef  = 2;
  // Word number field of a cache address (bits 34-35).
  localparam int unsigned WdW      = 2;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } state_e;

  // Odd parity: a slice is bad when data plus parity holds an even number of ones.
  function automatic logic slice_par_err(input logic [8:0] data, input logic par);
    return ~(^{data, par});
  endfunction

endpackage

// File: rtl/csh_wb_fifo.sv
// Small synchronous FIFO buffering read-back cache words (data plus parity) for transmission.
module csh_wb_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 40
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [Width-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [Width-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             wr, rd;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign full_o    = (cnt_q == CntW'(Depth));
  assign empty_o   = (cnt_q == '0);
  assign wr        = wr_en_i && !full_o;
  assign rd        = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr ? next_ptr(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd ? next_ptr(rd_ptr_q) : rd_ptr_q;
    cnt_d    = cnt_q;
    unique case ({wr, rd})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/cache_wb_xmt.sv
// Cache line writeback: reads WORDS words of one way/line and streams them to memory with
// ready/valid handshaking, flagging the first word whose parity is bad.
module cache_wb_xmt
  import cache_wb_xmt_pkg::*;
#(
  parameter int unsigned WORDS  = WordsDef,
  parameter int unsigned LINE_W = LineWDef,
  parameter int unsigned WAY_W  = WayWDef
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_req_h,
  input  logic [LINE_W-1:0]     wb_line_h,
  input  logic [WAY_W-1:0]      wb_way_h,
  output logic                  wb_ack_h,
  output logic                  wb_done_h,
  output logic                  csh_rd_en_h,
  output logic [LINE_W+WdW-1:0] csh_rd_adr_h,
  output logic [WAY_W-1:0]      csh_rd_way_h,
  input  logic [35:0]           cache_data_h,
  input  logic [3:0]            csh_par_bit_h,
  output logic [35:0]           cache_to_mem_h,
  output logic                  cache_to_mem_vld_h,
  input  logic                  mem_rdy_h,
  output logic [LINE_W+WdW-1:0] cache_to_mem_adr_h,
  output logic                  cache_to_mem_last_h,
  output logic                  csh_par_err_h,
  output logic [WdW-1:0]        csh_par_err_wd_h
);
  localparam logic [WdW-1:0] LastWd = WdW'(WORDS - 1);
  localparam int unsigned    FifoW  = 40;

  state_e             state_q, state_d;
  logic [LINE_W-1:0]  line_q;
  logic [WAY_W-1:0]   way_q;
  logic [WdW-1:0]     rd_cnt_q, rd_cnt_d, tx_cnt_q, tx_cnt_d, err_wd_q, err_wd_d;
  logic               err_q, err_d, rd_pend_q;
  logic               ack, rd_en, push, pop, head_err;
  logic               fifo_full, fifo_empty;
  logic [FifoW-1:0]   fifo_rdata;
  logic [3:0]         slice_err;

  function automatic logic [WdW-1:0] next_wd(input logic [WdW-1:0] wd);
    return (wd == LastWd) ? '0 : wd + WdW'(1);
  endfunction

  assign ack   = (state_q == StIdle) && wb_req_h && !reset;
  assign rd_en = (state_q == StRead);
  // Data returns one cycle after the strobe; a pending read is dropped by reset.
  assign push  = rd_pend_q && !fifo_full;
  assign pop   = !fifo_empty && mem_rdy_h;

  always_comb begin
    slice_err = '0;
    for (int i = 0; i < 4; i++) begin
      slice_err[i] = slice_par_err(fifo_rdata[9*i +: 9], fifo_rdata[36+i]);
    end
  end
  assign head_err = |slice_err;

  always_comb begin
    state_d  = state_q;
    rd_cnt_d = rd_cnt_q;
    tx_cnt_d = tx_cnt_q;
    err_d    = err_q;
    err_wd_d = err_wd_q;
    unique case (state_q)
      StIdle: begin
        if (ack) begin
          state_d  = StRead;
          rd_cnt_d = '0;
          tx_cnt_d = '0;
          err_d    = 1'b0;
          err_wd_d = '0;
        end
      end
      StRead: begin
        rd_cnt_d = next_wd(rd_cnt_q);
        if (rd_cnt_q == LastWd) state_d = StDrain;
      end
      StDrain: begin
        if (pop && (tx_cnt_q == LastWd)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Parity is judged as each word leaves; only the first bad word is recorded.
    if (pop) begin
      tx_cnt_d = next_wd(tx_cnt_q);
      if (head_err && !err_q) begin
        err_d    = 1'b1;
        err_wd_d = tx_cnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      line_q    <= '0;
      way_q     <= '0;
      rd_cnt_q  <= '0;
      tx_cnt_q  <= '0;
      err_q     <= 1'b0;
      err_wd_q  <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      tx_cnt_q  <= tx_cnt_d;
      err_q     <= err_d;
      err_wd_q  <= err_wd_d;
      rd_pend_q <= rd_en;
      if (ack) begin
        line_q <= wb_line_h;
        way_q  <= wb_way_h;
      end
    end
  end

  csh_wb_fifo #(
    .Depth(WORDS),
    .Width(FifoW)
  ) u_fifo (
    .clk_i    (clk),
    .rst_i    (reset),
    .wr_en_i  (push),
    .wr_data_i({csh_par_bit_h, cache_data_h}),
    .rd_en_i  (pop),
    .rd_data_o(fifo_rdata),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  assign wb_ack_h            = ack;
  assign wb_done_h           = (state_q == StDone);
  assign csh_rd_en_h         = rd_en;
  assign csh_rd_adr_h        = {line_q, rd_cnt_q};
  assign csh_rd_way_h        = way_q;
  assign cache_to_mem_vld_h  = !fifo_empty;
  assign cache_to_mem_h      = fifo_empty ? '0 : fifo_rdata[35:0];
  assign cache_to_mem_adr_h  = {line_q, tx_cnt_q};
  assign cache_to_mem_last_h = !fifo_empty && (tx_cnt_q == LastWd);
  assign csh_par_err_h       = err_q;
  assign csh_par_err_wd_h    = err_wd_q;

endmodule

// File: tb/tb_cache_wb_xmt.sv
// Bench for cache_wb_xmt: a cache RAM model answers reads, a scoreboard predicts each line's
// word stream, read addresses, completion timing and parity status.
module tb_cache_wb_xmt;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wb_req_h = 1'b0;
  logic [6:0]  wb_line_h = '0;
  logic [1:0]  wb_way_h = '0;
  logic        mem_rdy_h = 1'b0;
  logic [35:0] cache_data_h = '0;
  logic [3:0]  csh_par_bit_h = '0;
  logic        wb_ack_h, wb_done_h, csh_rd_en_h, cache_to_mem_vld_h, cache_to_mem_last_h;
  logic        csh_par_err_h;
  logic [8:0]  csh_rd_adr_h, cache_to_mem_adr_h;
  logic [1:0]  csh_rd_way_h, csh_par_err_wd_h;
  logic [35:0] cache_to_mem_h;

  always #5 clk = ~clk;

  cache_wb_xmt dut (
    .clk                (clk),
    .reset              (reset),
    .wb_req_h           (wb_req_h),
    .wb_line_h          (wb_line_h),
    .wb_way_h           (wb_way_h),
    .wb_ack_h           (wb_ack_h),
    .wb_done_h          (wb_done_h),
    .csh_rd_en_h        (csh_rd_en_h),
    .csh_rd_adr_h       (csh_rd_adr_h),
    .csh_rd_way_h       (csh_rd_way_h),
    .cache_data_h       (cache_data_h),
    .csh_par_bit_h      (csh_par_bit_h),
    .cache_to_mem_h     (cache_to_mem_h),
    .cache_to_mem_vld_h (cache_to_mem_vld_h),
    .mem_rdy_h          (mem_rdy_h),
    .cache_to_mem_adr_h (cache_to_mem_adr_h),
    .cache_to_mem_last_h(cache_to_mem_last_h),
    .csh_par_err_h      (csh_par_err_h),
    .csh_par_err_wd_h   (csh_par_err_wd_h)
  );

  typedef struct packed {
    logic [35:0] d;
    logic [8:0]  a;
    logic        l;
  } xfer_t;

  typedef struct {
    logic [6:0] line;
    logic [1:0] way;
    int         mode;
    int         n;
    logic [3:0] corr;
    logic [1:0] slice;
    logic       exp_err;
    logic [1:0] exp_wd;
  } vec_t;

  int n_cmp = 0, n_fail = 0, cyc = 0, n_done = 0, rd_seen = 0;
  int ack_cyc = -1000, done_cyc = -1000;
  // Driver values applied just after the next rising edge.
  logic rst_nx = 1'b1, req_nx = 1'b0;
  logic [6:0] line_nx = '0;
  logic [1:0] way_nx = '0;
  // Per-operation stimulus configuration.
  int rdy_mode = 0, rdy_n = 0;
  logic [3:0] corr_words = '0;
  logic [1:0] corr_slice = '0;
  logic [31:0] seed = '0;
  // Scoreboard state.
  bit op_active = 0, pend_v = 0, prev_stall = 0, exp_err = 0;
  logic [1:0] exp_wd = '0, cur_way = '0, pend_way = '0;
  logic [6:0] cur_line = '0;
  logic [8:0] pend_adr = '0;
  xfer_t exp_q[$];
  xfer_t prev_x;

  function automatic logic [35:0] ram_word(input logic [8:0] adr, input logic [1:0] way,
                                           input logic [31:0] s);
    return {s[3:0], s} ^ ({27'd0, adr} * 36'd777767) ^ {3'd0, way, 31'd0};
  endfunction

  function automatic logic [3:0] par_bits(input logic [35:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) p[i] = ~(^d[9*i +: 9]);
    return p;
  endfunction

  function automatic logic [63:0] all_out();
    return {wb_ack_h, wb_done_h, csh_rd_en_h, csh_rd_adr_h, csh_rd_way_h, cache_to_mem_h,
            cache_to_mem_vld_h, cache_to_mem_adr_h, cache_to_mem_last_h, csh_par_err_h,
            csh_par_err_wd_h};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: drive inputs after the edge, then sample and score the outputs.
  task automatic tick();
    int rel, idx;
    bit exp_rd;
    logic [35:0] d;
    logic [3:0] p;
    xfer_t e, cur;
    @(posedge clk);
    #1;
    cyc++;
    reset = rst_nx;
    wb_req_h = req_nx;
    wb_line_h = line_nx;
    wb_way_h = way_nx;
    rel = cyc - ack_cyc;
    case (rdy_mode)
      0: mem_rdy_h = 1'b1;
      1: mem_rdy_h = !(op_active && rel >= 1 && rel <= rdy_n);
      2: mem_rdy_h = op_active ? rel[0] : 1'b1;
      default: mem_rdy_h = 1'($urandom_range(0, 1));
    endcase
    if (pend_v) begin
      d = ram_word(pend_adr, pend_way, seed);
      p = par_bits(d);
      if (corr_words[pend_adr[1:0]]) p[corr_slice] = ~p[corr_slice];
    end else begin
      d = {4'($urandom), $urandom};
      p = 4'($urandom);
    end
    pend_v = 0;
    cache_data_h = d;
    csh_par_bit_h = p;
    #1;
    if (reset) begin
      op_active = 0;
      prev_stall = 0;
      exp_q.delete();
      return;
    end
    if (wb_ack_h) begin
      check("ack_while_busy", 64'(op_active), 64'd0);
      op_active = 1;
      ack_cyc = cyc;
      rd_seen = 0;
      cur_line = wb_line_h;
      cur_way = wb_way_h;
      exp_err = 0;
      exp_wd = '0;
      for (int w = 3; w >= 0; w--) if (corr_words[w]) begin exp_err = 1; exp_wd = 2'(w); end
      exp_q.delete();
      for (int w = 0; w < 4; w++) begin
        e.a = {cur_line, 2'(w)};
        e.d = ram_word(e.a, cur_way, seed);
        e.l = (w == 3);
        exp_q.push_back(e);
      end
    end
    rel = cyc - ack_cyc;
    if (op_active && rel == 1) check("err_cleared", {csh_par_err_h, csh_par_err_wd_h}, 64'd0);
    exp_rd = op_active && rel >= 1 && rel <= 4;
    if (csh_rd_en_h || exp_rd) begin
      check("rd_en", 64'(csh_rd_en_h), 64'(exp_rd));
      if (csh_rd_en_h && exp_rd)
        check("rd_adr_way", {csh_rd_way_h, csh_rd_adr_h}, {cur_way, cur_line, 2'(rel - 1)});
    end
    if (csh_rd_en_h) begin
      pend_v = 1;
      pend_adr = csh_rd_adr_h;
      pend_way = csh_rd_way_h;
      rd_seen++;
    end
    cur = '{d: cache_to_mem_h, a: cache_to_mem_adr_h, l: cache_to_mem_last_h};
    if (prev_stall) check("stall_hold", {cache_to_mem_vld_h, cur}, {1'b1, prev_x});
    if (cache_to_mem_vld_h && mem_rdy_h) begin
      if (exp_q.size() == 0) begin
        check("xfer_extra", 64'(cache_to_mem_vld_h), 64'd0);
      end else begin
        idx = 4 - exp_q.size();
        e = exp_q.pop_front();
        check("xfer_word", cur, e);
        if (rdy_mode == 0) check("xfer_time", 64'(rel), 64'(3 + idx));
      end
    end
    prev_stall = cache_to_mem_vld_h && !mem_rdy_h;
    prev_x = cur;
    if (wb_done_h) begin
      check("done_active", 64'(op_active), 64'd1);
      check("done_all_sent", 64'(exp_q.size()), 64'd0);
      if (rdy_mode == 0) check("done_time", 64'(rel), 64'd7);
      check("par_err", {csh_par_err_h, csh_par_err_wd_h}, {exp_err, exp_wd});
      op_active = 0;
      done_cyc = cyc;
      n_done++;
    end
  endtask

  task automatic wait_ack();
    int k = 0;
    while (!op_active && k < 20) begin tick(); k++; end
    check("ack_seen", 64'(op_active), 64'd1);
  endtask

  task automatic wait_done();
    int nd = n_done, k = 0;
    while (n_done == nd && k < 200) begin tick(); k++; end
    check("done_seen", 64'(n_done - nd), 64'd1);
  endtask

  task automatic setup(input int mode, input int n, input logic [3:0] corr, input logic [1:0] sl);
    rdy_mode = mode;
    rdy_n = n;
    corr_words = corr;
    corr_slice = sl;
    seed = $urandom;
  endtask

  task automatic run_op(input logic [6:0] line, input logic [1:0] way, input int mode,
                        input int n, input logic [3:0] corr, input logic [1:0] sl);
    setup(mode, n, corr, sl);
    line_nx = line;
    way_nx = way;
    req_nx = 1;
    wait_ack();
    req_nx = 0;
    wait_done();
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{7'd5,    2'd2, 0, 0,  4'b0000, 2'd0, 1'b0, 2'd0};
    vecs[1] = '{7'd9,    2'd1, 1, 10, 4'b0000, 2'd0, 1'b0, 2'd0};
    vecs[2] = '{7'h33,   2'd3, 0, 0,  4'b1100, 2'd1, 1'b1, 2'd2};
    vecs[3] = '{7'h7f,   2'd0, 0, 0,  4'b0000, 2'd0, 1'b0, 2'd0};
    vecs[4] = '{7'h2a,   2'd1, 2, 0,  4'b0000, 2'd0, 1'b0, 2'd0};
    vecs[5] = '{7'd0,    2'd0, 0, 0,  4'b0001, 2'd3, 1'b1, 2'd0};
    vecs[6] = '{7'h11,   2'd2, 1, 3,  4'b1010, 2'd0, 1'b1, 2'd1};

    // Reset with a request pending: no ack, all outputs zero, ack right after release.
    setup(0, 0, 4'b0000, 2'd0);
    rst_nx = 1;
    req_nx = 1;
    line_nx = 7'd5;
    way_nx = 2'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i >= 1) check("reset_outputs", all_out(), 64'd0);
    end
    rst_nx = 0;
    tick();
    check("ack_after_reset", 64'(wb_ack_h), 64'd1);
    req_nx = 0;
    wait_done();

    for (int i = 0; i < 7; i++) begin
      run_op(vecs[i].line, vecs[i].way, vecs[i].mode, vecs[i].n, vecs[i].corr, vecs[i].slice);
      check("tbl_par_err", {csh_par_err_h, csh_par_err_wd_h}, {vecs[i].exp_err, vecs[i].exp_wd});
      repeat (2) tick();
    end

    // Request held high: the second ack lands on the cycle after done.
    setup(0, 0, 4'b0100, 2'd2);
    line_nx = 7'd3;
    way_nx = 2'd3;
    req_nx = 1;
    wait_ack();
    wait_done();
    tick();
    check("held_reack", {wb_ack_h, 32'(cyc - done_cyc)}, {1'b1, 32'd1});
    req_nx = 0;
    wait_done();

    // Reset in the cycle after the second read aborts the operation cleanly.
    setup(0, 0, 4'b0000, 2'd0);
    line_nx = 7'h21;
    way_nx = 2'd1;
    req_nx = 1;
    wait_ack();
    req_nx = 0;
    for (int k = 0; k < 10 && rd_seen < 2; k++) tick();
    check("abort_two_reads", 64'(rd_seen), 64'd2);
    rst_nx = 1;
    tick();
    rst_nx = 0;
    tick();
    check("abort_zero", all_out(), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("abort_quiet", {cache_to_mem_vld_h, wb_done_h}, 64'd0);
    end
    run_op(7'h44, 2'd3, 0, 0, 4'b0000, 2'd0);

    for (int i = 0; i < 15; i++) begin
      run_op(7'($urandom), 2'($urandom), 3, 0,
             ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000, 2'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
